led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator for the board's LED bank: drives NLEDS outputs with one of four animated patterns, stepping at a prescaled rate. The patterns are binary count, Gray count, bouncing scanner and fill bar. A debounced push-button cycles the pattern mode. It sits between the board clock and the LED pins, and replaces a fixed free-running binary LED counter as the top-level demo/status block.

## Interface
- NLEDS, 8, number of LED outputs; legal range 2..32.
- LOG2DELAY, 19, pattern step period is 2^LOG2DELAY clk cycles.
- DEBOUNCE_BITS, 16, the synchronised button must hold a new level for 2^DEBOUNCE_BITS consecutive cycles to be accepted.
- clk  in  1  single system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- btn  in  1  raw push-button, active-high, asynchronous to clk.
- leds  out  NLEDS  registered LED drive; leds[0] is LED index 0.
- mode  out  2  current pattern mode: 0 binary, 1 Gray, 2 scanner, 3 fill.

## Operation
- Reset (resetn low at a clk edge) clears all registers:
  - prescaler=0, cnt=0, pos=0, dir=up, level=0
  - mode=0, leds=0
  - sync FFs=0, db_state=0, db_cnt=0
- Button path:
  - Two-FF synchroniser produces s.
  - If s==db_state, db_cnt<=0.
  - Otherwise db_cnt increments. On the cycle db_cnt==2^DEBOUNCE_BITS-1 with s still !=db_state: db_state<=s and db_cnt<=0.
  - press is a one-cycle pulse on the cycle after db_state rises 0->1. Release (1->0) does nothing.
- Prescaler: LOG2DELAY-bit free-running up-counter. tick is asserted when prescaler is all ones.
- On press (priority over tick in the same cycle):
  - mode<=mode+1, wrapping 3->0.
  - prescaler, cnt, pos, level <= 0; dir<=up.
  - The tick of that cycle is discarded.
- On tick without press, only the active mode's state advances:
  - Modes 0/1: cnt<=cnt+1, NLEDS bits, wrapping all-ones->0.
  - Mode 2: if dir=up and pos==NLEDS-1, then dir<=down and pos<=NLEDS-2. If dir=down and pos==0, then dir<=up and pos<=1. Otherwise pos moves one step in dir.
  - Mode 3: level<=level+1; level==NLEDS wraps to 0. level is $clog2(NLEDS+1) bits wide.
- Output mapping, registered every cycle from the current state:
  - Mode 0: leds<=cnt.
  - Mode 1: leds<=cnt^(cnt>>1).
  - Mode 2: leds<=1<<pos; exactly one LED lit.
  - Mode 3: leds<=(1<<level)-1, a thermometer code; level==NLEDS gives all ones.
- State of inactive modes does not advance.

## Timing
- Step period: exactly 2^LOG2DELAY cycles between state updates.
- The first update after reset or press occurs 2^LOG2DELAY cycles after the clearing edge.
- leds lags state by one cycle. The mode port reflects the mode register with no extra delay.
- Button latency from a clean btn rise to a mode change:
  - 2 cycles of synchroniser.
  - 2^DEBOUNCE_BITS cycles of qualification (db_state rises).
  - +1 cycle for the press pulse, with mode updating at that edge.
  - leds shows the new mode's reset pattern one cycle later.
- Bounces shorter than 2^DEBOUNCE_BITS cycles restart qualification and cause no mode change.
- Scanner period is 2*NLEDS-2 ticks. Fill period is NLEDS+1 ticks. Count period is 2^NLEDS ticks.
- resetn low mid-operation takes effect at the next edge regardless of pending tick or press. leds reads 0 on the cycle after reset.

## Test plan
Bench parameters: NLEDS=4, LOG2DELAY=2, DEBOUNCE_BITS=2.
- Reset, mode 0, no button:
  - Required: leds=0 after reset.
  - Required: leds steps 1,2,3,...,15,0 every 4 cycles; mode=0.
- Mode 1 (one clean press):
  - Required: after the press, leds sequence 0,1,3,2,6,7,5,4,12,...,8,0.
  - Required: consecutive values differ in exactly one bit.
- Mode 2 (two presses):
  - Required: leds 1,2,4,8,4,2,1,2,... with a 6-tick period.
  - Required: exactly one bit set at all times.
- Mode 3 (three presses):
  - Required: leds 0,1,3,7,15,0,... with a 5-tick period.
  - A fourth press: mode returns to 0 and leds restarts at 0.
- Bounce rejection:
  - Stimulus: btn toggled high/low with 3-cycle pulses for 40 cycles, then held high for 10 cycles.
  - Required: exactly one mode increment, with mode change 2+4+1 cycles after the final stable rise.
  - Required: no change on release.
- Collision and reset:
  - Stimulus: press pulse forced on a tick cycle.
  - Required: mode advances, state is cleared, the tick is dropped, and the next step comes 4 cycles later.
  - Stimulus: resetn low for one cycle mid-scanner.
  - Required: mode=0 and leds=0 next cycle, and counting resumes from 0.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: four animated patterns (binary, Gray, scanner, fill)
// stepped by a power-of-two prescaler; a debounced button cycles the mode.
module led_pattern_gen #(
  parameter int NLEDS         = 8,
  parameter int LOG2DELAY     = 19,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             btn,
  output logic [NLEDS-1:0] leds,
  output logic [1:0]       mode
);

  localparam int PW = $clog2(NLEDS);
  localparam int LW = $clog2(NLEDS + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(NLEDS - 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(NLEDS);

  typedef enum logic [1:0] {M_BIN, M_GRAY, M_SCAN, M_FILL} mode_t;
  typedef enum logic {UP, DN} dir_t;

  logic                     sync1, sync2;
  logic                     db_state, db_prev;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic                     press;
  logic [LOG2DELAY-1:0]     presc;
  logic                     tick;
  mode_t                    mode_q, mode_d;
  logic [NLEDS-1:0]         cnt;
  logic [PW-1:0]            pos;
  dir_t                     dir;
  logic [LW-1:0]            level;
  logic [NLEDS-1:0]         scan_bits, fill_bits;

  // two-FF synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // accept a new level only after it has been held for a full db_cnt wrap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      db_state <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      db_prev <= db_state;
      if (sync2 == db_state) begin
        db_cnt <= '0;
      end else if (&db_cnt) begin
        db_state <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // one-cycle pulse in the cycle following an accepted rising level
  assign press = db_state & ~db_prev;

  // free-running step prescaler, restarted by a press
  always_ff @(posedge clk) begin
    if (!resetn || press) presc <= '0;
    else                  presc <= presc + 1'b1;
  end

  assign tick = &presc;

  // mode register
  always_ff @(posedge clk) begin
    if (!resetn) mode_q <= M_BIN;
    else         mode_q <= mode_d;
  end

  // mode advances on each press, wrapping fill back to binary
  always_comb begin
    mode_d = mode_q;
    if (press) begin
      case (mode_q)
        M_BIN:  mode_d = M_GRAY;
        M_GRAY: mode_d = M_SCAN;
        M_SCAN: mode_d = M_FILL;
        M_FILL: mode_d = M_BIN;
      endcase
    end
  end

  assign mode = mode_q;

  // animation state: cleared by press (which swallows a coincident tick),
  // otherwise only the active mode's state moves on a tick
  always_ff @(posedge clk) begin
    if (!resetn || press) begin
      cnt   <= '0;
      pos   <= '0;
      dir   <= UP;
      level <= '0;
    end else if (tick) begin
      case (mode_q)
        M_BIN, M_GRAY: cnt <= cnt + 1'b1;
        M_SCAN: begin
          if (dir == UP) begin
            if (pos == POS_MAX) begin
              dir <= DN;
              pos <= pos - 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              dir <= UP;
              pos <= pos + 1'b1;
            end else begin
              pos <= pos - 1'b1;
            end
          end
        end
        M_FILL: level <= (level == LVL_MAX) ? '0 : level + 1'b1;
      endcase
    end
  end

  // per-LED decode of the scanner position and the fill thermometer
  for (genvar i = 0; i < NLEDS; i++) begin : g_led
    assign scan_bits[i] = (pos == PW'(i));
    assign fill_bits[i] = (LW'(i) < level);
  end

  // registered LED drive from the current mode and state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds <= '0;
    end else begin
      case (mode_q)
        M_BIN:  leds <= cnt;
        M_GRAY: leds <= cnt ^ (cnt >> 1);
        M_SCAN: leds <= scan_bits;
        M_FILL: leds <= fill_bits;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed phases plus random button/reset traffic,
// checked every cycle against a behavioural model of the pattern rules.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int D  = 2;
  localparam int DLY = 1 << L;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         btn = 1'b0;
  logic [N-1:0] leds;
  logic [1:0]   mode;

  led_pattern_gen #(.NLEDS(N), .LOG2DELAY(L), .DEBOUNCE_BITS(D)) dut (
    .clk(clk), .resetn(resetn), .btn(btn), .leds(leds), .mode(mode)
  );

  always #5 clk = ~clk;

  // model state
  bit           hist [0:5];   // hist[k] = btn seen at edge e-1-k
  bit           m_db, m_pend;
  int           m_mode, m_steps, m_since;
  bit           prev_gray;
  logic [N-1:0] prev_leds;
  int           nvec, nerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // pattern after k steps in mode md, straight from the pattern definitions
  function automatic int pat(int md, int k);
    int i, p, g;
    case (md)
      0: return k % (1 << N);
      1: begin g = k % (1 << N); return g ^ (g >> 1); end
      2: begin i = k % (2*N-2); p = (i < N) ? i : (2*N-2) - i; return 1 << p; end
      default: begin i = k % (N+1); return (1 << i) - 1; end
    endcase
  endfunction

  // one clock: advance the model by the inputs present at the edge, then check
  task automatic step();
    int pre_mode, exp_leds;
    bit rst_now, win_same;
    @(posedge clk);
    pre_mode = m_mode;
    rst_now  = !resetn;
    if (rst_now) begin
      for (int k = 0; k < 6; k++) hist[k] = 1'b0;
      m_db = 0; m_pend = 0; m_mode = 0; m_steps = 0; m_since = 0;
      exp_leds = 0;
    end else begin
      exp_leds = pat(m_mode, m_steps);
      m_since++;
      if (m_pend) begin
        m_mode  = (m_mode + 1) % 4;
        m_steps = 0;
        m_since = 0;
      end else if (m_since % DLY == 0) begin
        m_steps++;
      end
      // synchronised button level has been constant for 2^D consecutive edges
      win_same = 1;
      for (int k = 2; k <= (1 << D); k++) if (hist[k] != hist[1]) win_same = 0;
      m_pend = 0;
      if (win_same && hist[1] != m_db) begin
        m_db   = hist[1];
        m_pend = hist[1];
      end
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn;
    end
    #1;
    chk("leds", 32'(leds), 32'(exp_leds));
    chk("mode", 32'(mode), 32'(m_mode));
    if (!rst_now && pre_mode == 2) chk("onehot", $countones(leds), 1);
    if (!rst_now && pre_mode == 1 && prev_gray && leds != prev_leds)
      chk("gray1b", $countones(leds ^ prev_leds), 1);
    prev_gray = !rst_now && pre_mode == 1;
    prev_leds = leds;
  endtask

  task automatic press_btn();
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    nvec = 0; nerr = 0; prev_gray = 0; prev_leds = '0;
    for (int k = 0; k < 6; k++) hist[k] = 1'b0;
    m_db = 0; m_pend = 0; m_mode = 0; m_steps = 0; m_since = 0;

    // reset, then free-running binary count through a full wrap
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    repeat (70) step();

    // Gray, scanner, fill, and back to binary
    press_btn(); repeat (70) step();
    press_btn(); repeat (30) step();
    press_btn(); repeat (30) step();
    press_btn(); repeat (20) step();

    // bounce: 3-cycle pulses never qualify, the final long hold does once
    for (int k = 0; k < 40; k++) begin
      btn = ((k / 3) % 2 == 0);
      step();
    end
    btn = 1'b1; repeat (10) step();
    btn = 1'b0; repeat (20) step();

    // collision: time the rise so the press lands on a tick cycle
    for (int k = 0; k < 8 && (m_since % DLY) != 1; k++) step();
    btn = 1'b1; repeat (10) step();
    btn = 1'b0; repeat (20) step();

    // reset in the middle of the scanner
    for (int k = 0; k < 4 && m_mode != 2; k++) press_btn();
    repeat (15) step();
    resetn = 1'b0; step();
    resetn = 1'b1; repeat (70) step();

    // random button activity with occasional resets
    repeat (300) begin
      if ($urandom_range(0, 29) == 0) begin
        resetn = 1'b0; step(); resetn = 1'b1;
      end
      btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 9)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
